// File: rtl/multiplicador.sv
// multiplicador: sequential signed 32x32 multiplier, radix-2 Booth, one step
// per clock, fixed 32-step latency. Shares the divider's control handshake:
// a level-sampled start strobe in, a one-cycle done pulse out, and the
// product delivered into HI/LO.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high reset
//   MultCtrl - start strobe; must be seen low before it can start again
//   a, b     - signed multiplicand / multiplier, captured at start
//   multOut  - registered done pulse, one cycle per completed product
//   HI, LO   - registered product bits [63:32] / [31:0]
module multiplicador (
  input  logic        clk,
  input  logic        reset,
  input  logic        MultCtrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        multOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [32:0] m;       // sign-extended multiplicand
  logic [32:0] acc;     // 33 bits so acc - M cannot overflow for a = 0x80000000
  logic [31:0] q;       // multiplier, shifted out one bit per step
  logic        q_1;     // Booth look-behind bit
  logic [4:0]  count;
  logic        armed;   // start re-armed only after MultCtrl seen low

  logic [32:0] sum;
  logic [32:0] acc_next;
  logic [31:0] q_next;

  // Booth step: add/subtract M by the {Q[0], q_1} pair, then arithmetic
  // shift right of {acc, Q, q_1}.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_next = {sum[32], sum[32:1]};
    q_next   = {sum[0], q[31:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      HI      <= '0;
      LO      <= '0;
      multOut <= 1'b0;
      count   <= '0;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      armed   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          multOut <= 1'b0;
          if (MultCtrl && armed) begin
            m     <= {a[31], a};
            acc   <= '0;
            q     <= b;
            q_1   <= 1'b0;
            count <= '0;
            armed <= 1'b0;
            state <= RUN;
          end else if (!MultCtrl) begin
            armed <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          q_1   <= q[0];
          count <= count + 5'd1;
          if (count == 5'd31) begin
            // Post-shift {acc[31:0], Q} is the full 64-bit product.
            HI      <= acc_next[31:0];
            LO      <= q_next;
            multOut <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          multOut <= 1'b0;
          if (!MultCtrl) armed <= 1'b1;
          state <= IDLE;
        end
        default: begin
          multOut <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador.sv
module tb_multiplicador;

  logic        clk = 1'b0;
  logic        reset;
  logic        MultCtrl;
  logic [31:0] a, b;
  logic        multOut;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  multiplicador dut (
    .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .a(a), .b(b),
    .multOut(multOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse MultCtrl for one cycle, wait for the done pulse (bounded), then
  // check latency, product and pulse width.
  task automatic run_mult(input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] prod, input string tag);
    int n;
    @(negedge clk); a = av; b = bv; MultCtrl = 1'b1;
    @(negedge clk); MultCtrl = 1'b0;
    n = 1;
    while (multOut !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_prod"}, {HI, LO}, prod);
    @(negedge clk);
    chk({tag, "_pulse_fall"}, 64'(multOut), 64'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; MultCtrl = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_out", {HI, LO}, 64'd0);
    chk("reset_done", 64'(multOut), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_mult(32'd3, 32'd5, 64'h00000000_0000000F, "3x5");
    run_mult(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, "m7x6");
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "m1xm1");
    run_mult(32'h80000000, 32'h80000000, 64'h40000000_00000000, "minxmin");
    run_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, "maxxmax");
    run_mult(32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, "minxmax");

    // Held strobe: exactly one product.
    @(negedge clk); a = 32'd2; b = 32'd4; MultCtrl = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (multOut === 1'b1) pulses++;
    end
    chk("held_pulses", 64'(pulses), 64'd1);
    chk("held_prod", {HI, LO}, 64'd8);
    MultCtrl = 1'b0;
    @(negedge clk); b = 32'd5; MultCtrl = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      MultCtrl = 1'b0;
      if (multOut === 1'b1) pulses++;
    end
    chk("rearm_pulses", 64'(pulses), 64'd1);
    chk("rearm_prod", {HI, LO}, 64'd10);

    // Inputs changed and strobe dropped mid-run are ignored.
    @(negedge clk); a = 32'd9; b = 32'd9; MultCtrl = 1'b1;
    repeat (5) @(negedge clk);
    a = 32'd1234; b = 32'hFFFF0000; MultCtrl = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (multOut === 1'b1) begin
        pulses++;
        chk("midrun_prod", {HI, LO}, 64'd81);
      end
    end
    chk("midrun_pulses", 64'(pulses), 64'd1);

    // Reset mid-run aborts immediately and asynchronously.
    run_mult(32'd3, 32'd5, 64'h00000000_0000000F, "pre_rst");
    @(negedge clk); a = 32'd11; b = 32'd13; MultCtrl = 1'b1;
    @(negedge clk); MultCtrl = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_prod", {HI, LO}, 64'd0);
    chk("async_rst_done", 64'(multOut), 64'd0);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (multOut === 1'b1) pulses++;
    end
    chk("post_rst_pulses", 64'(pulses), 64'd0);
    chk("post_rst_hold", {HI, LO}, 64'd0);
    run_mult(32'd11, 32'd13, 64'd143, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
